muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide unit, the multi-cycle companion to the single-cycle `alu`, parametrised in data width. It accepts one operation per start pulse, computes it over a fixed number of cycles with a radix-2 shift-add/restoring datapath, and returns the result with a one-cycle valid pulse. It sits beside the ALU in the execute stage; the control unit stalls the pipeline while `MD_Busy` is high.

## Interface
- `DWIDTH`, 32: operand and result width; legal values are 8 to 64.
- `Clk` in 1: clock; all state updates on the rising edge.
- `Rst_N` in 1: reset, asynchronous, active-low.
- `MD_Start` in 1: request; sampled only when idle.
- `MD_OP` in 3: operation, RV32M funct3 encoding:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `MD_In_A` in DWIDTH: operand A (multiplicand or dividend).
- `MD_In_B` in DWIDTH: operand B (multiplier or divisor).
- `MD_Kill` in 1: synchronous abort of the operation in flight (pipeline flush).
- `MD_Busy` out 1: an operation is in progress.
- `MD_Valid` out 1: one-cycle pulse; `MD_Out` is new this cycle.
- `MD_Out` out DWIDTH: result; held until the next completion.
- `MD_Zero_Flag` out 1: `MD_Out == 0`, registered with `MD_Out`.

## Operation
- The FSM has three states: IDLE, CALC and FIX.
- **IDLE**
  - When `MD_Start` is high, capture the op and operands, set iteration counter = DWIDTH, and go to CALC.
  - Signed ops capture absolute values and record sign(A) and sign(B). MULHSU treats B as unsigned.
- **CALC**
  - Runs one iteration per cycle and decrements the counter; when the counter reaches 0 the next state is FIX.
  - Multiply: shift-add over a 2·DWIDTH-bit product register.
  - Divide: restoring shift-subtract, producing a DWIDTH-bit quotient and remainder.
- **FIX** (one cycle)
  - Apply the sign correction and select the result, then register `MD_Out`, `MD_Zero_Flag` and `MD_Valid`=1, and return to IDLE.
  - MUL returns product[DWIDTH-1:0]. MULH, MULHSU and MULHU return product[2·DWIDTH-1:DWIDTH].
  - The product is negated when sign(A)≠sign(B) (for MULHSU, when sign(A) is set).
  - DIV/REM: the quotient is negated when signs differ; the remainder takes sign(A).
  - Divide by zero, overriding the sign fix:
    - DIV and DIVU return all ones.
    - REM and REMU return the original A.
  - Signed overflow (A = most-negative, B = −1): DIV returns most-negative and REM returns 0. The datapath produces this naturally; no special case is needed beyond confirming it.
- `MD_Kill` in CALC or FIX:
  - The next state is IDLE, with no `MD_Valid`, and `MD_Out`/`MD_Zero_Flag` unchanged.
  - `MD_Kill` in IDLE has no effect.
  - `MD_Kill` and `MD_Start` high together in IDLE: the start is accepted.
- `MD_Start` while busy is ignored; no queueing.
- `MD_OP` and operands are don't-care after the capture edge.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `MD_Busy`=0, `MD_Valid`=0, `MD_Out`=0, `MD_Zero_Flag`=1.
- Reset mid-operation: all of the above apply immediately, with no valid pulse after release.
- Latency, with E0 the capture edge:
  - `MD_Busy`=1 from E0 until edge E(DWIDTH+1).
  - `MD_Valid`=1 for exactly the one cycle after E(DWIDTH+1), i.e. DWIDTH+2 cycles from the request cycle. That is 34 for DWIDTH=32, independent of op and operands.
  - `MD_Busy` is 0 during the valid cycle.
- Back-to-back: `MD_Start` in the `MD_Valid` cycle is accepted, giving a throughput of one op per DWIDTH+2 cycles.
- Kill at edge Ek gives `MD_Busy`=0 in the following cycle; a new start is accepted in that same cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `riscv_pkg`:
  - `md_op_t` enum with the eight funct3 encodings.
  - FSM state typedef.
  - `MD_CNT_W = $clog2(DWIDTH+1)`, the counter width.
- Single module. No sub-module is needed; the iteration datapath and the sign fix share the A/B/accumulator registers.

## Test plan
1. MUL with A=0x00000007, B=0xFFFFFFFD → `MD_Out`=0xFFFFFFEB and `MD_Zero_Flag`=0. `MD_Valid` pulses exactly once, 34 cycles after the request; `MD_Busy` is high for 33 cycles.
2. Operands A=B=0xFFFFFFFF:
   - MULHU → 0xFFFFFFFE.
   - MULH → 0x00000000 with `MD_Zero_Flag`=1.
   - MULHSU → 0xFFFFFFFF.
3. Signed and unsigned divide:
   - DIV −7/2 (0xFFFFFFF9, 0x00000002) → 0xFFFFFFFD.
   - REM on the same operands → 0xFFFFFFFF.
   - DIVU on the same operands → 0x7FFFFFFC.
4. Corner cases:
   - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 0x00000005.
   - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM on the same operands → 0.
5. Kill and back-to-back:
   - Start MUL, assert `MD_Kill` at cycle 10 → no `MD_Valid`, `MD_Out` keeps its prior value, and `MD_Busy`=0 the next cycle.
   - `MD_Start` pulsed while busy is ignored.
   - A start issued in a `MD_Valid` cycle completes 34 cycles later.
6. Reset mid-operation: drive `Rst_N` low at cycle 15 of a DIV → outputs are 0/0/0/`MD_Zero_Flag`=1 before the next clock edge, and no `MD_Valid` occurs after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32M definitions for the iterative multiply/divide unit.
// Holds the funct3 op encoding, FSM states and iteration-counter sizing.
package riscv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  localparam int MD_DWIDTH = 32;
  localparam int MD_CNT_W  = $clog2(MD_DWIDTH + 1);

  // Divide ops occupy the upper half of the funct3 space.
  function automatic logic md_is_div(input md_op_t op);
    logic [2:0] code;
    code = op;
    return code[2];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: shift-add multiply, restoring
// divide, one result per start after DWIDTH+2 cycles, killable mid-flight.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              Clk,
  input  logic              Rst_N,
  input  logic              MD_Start,
  input  logic [2:0]        MD_OP,
  input  logic [DWIDTH-1:0] MD_In_A,
  input  logic [DWIDTH-1:0] MD_In_B,
  input  logic              MD_Kill,
  output logic              MD_Busy,
  output logic              MD_Valid,
  output logic [DWIDTH-1:0] MD_Out,
  output logic              MD_Zero_Flag
);

  localparam int CNT_W = $clog2(DWIDTH + 1);
  localparam logic [CNT_W-1:0]    CNT_INIT = CNT_W'(DWIDTH);
  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DWIDTH-1:0]   ONE_W    = {{(DWIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*DWIDTH-1:0] ONE_2W   = {{(2*DWIDTH-1){1'b0}}, 1'b1};

  md_state_t           state_r, state_nxt_s;
  md_op_t              op_r, op_in_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [DWIDTH-1:0]   opnd_r, a_orig_r;
  logic [2*DWIDTH-1:0] acc_r;
  logic                sign_a_r, sign_b_r, b_zero_r;
  logic                busy_r, valid_r, zero_r;
  logic [DWIDTH-1:0]   out_r;

  logic                sa_s, sb_s;
  logic [DWIDTH-1:0]   a_abs_s, b_abs_s;
  logic [DWIDTH:0]     mul_sum_s, rem_sh_s, diff_s;
  logic [2*DWIDTH-1:0] mul_nxt_s, div_nxt_s, prod_fix_s;
  logic [DWIDTH-1:0]   quo_fix_s, rem_fix_s, result_s;

  // Operand capture: signed ops carry magnitudes plus recorded signs.
  always_comb begin
    op_in_s = md_op_t'(MD_OP);
    sa_s    = 1'b0;
    sb_s    = 1'b0;
    if (op_in_s inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) begin
      sa_s = MD_In_A[DWIDTH-1];
    end else begin
      sa_s = 1'b0;
    end
    if (op_in_s inside {MD_MULH, MD_DIV, MD_REM}) begin
      sb_s = MD_In_B[DWIDTH-1];
    end else begin
      sb_s = 1'b0;
    end
    a_abs_s = sa_s ? ((~MD_In_A) + ONE_W) : MD_In_A;
    b_abs_s = sb_s ? ((~MD_In_B) + ONE_W) : MD_In_B;
  end

  // One radix-2 step: acc holds {hi, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum_s = {1'b0, acc_r[2*DWIDTH-1:DWIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(DWIDTH+1){1'b0}});
    mul_nxt_s = {mul_sum_s, acc_r[DWIDTH-1:1]};
    rem_sh_s  = {acc_r[2*DWIDTH-1:DWIDTH], acc_r[DWIDTH-1]};
    diff_s    = rem_sh_s - {1'b0, opnd_r};
    if (diff_s[DWIDTH] == 1'b0) begin
      div_nxt_s = {diff_s[DWIDTH-1:0], acc_r[DWIDTH-2:0], 1'b1};
    end else begin
      div_nxt_s = {rem_sh_s[DWIDTH-1:0], acc_r[DWIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and result select; divide-by-zero overrides the sign fix.
  always_comb begin
    prod_fix_s = (sign_a_r ^ sign_b_r) ? ((~acc_r) + ONE_2W) : acc_r;
    quo_fix_s  = (sign_a_r ^ sign_b_r) ? ((~acc_r[DWIDTH-1:0]) + ONE_W) : acc_r[DWIDTH-1:0];
    rem_fix_s  = sign_a_r ? ((~acc_r[2*DWIDTH-1:DWIDTH]) + ONE_W) : acc_r[2*DWIDTH-1:DWIDTH];
    case (op_r)
      MD_MUL:                        result_s = prod_fix_s[DWIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result_s = prod_fix_s[2*DWIDTH-1:DWIDTH];
      MD_DIV:   result_s = b_zero_r ? {DWIDTH{1'b1}} : quo_fix_s;
      MD_DIVU:  result_s = b_zero_r ? {DWIDTH{1'b1}} : acc_r[DWIDTH-1:0];
      MD_REM:   result_s = b_zero_r ? a_orig_r : rem_fix_s;
      MD_REMU:  result_s = b_zero_r ? a_orig_r : acc_r[2*DWIDTH-1:DWIDTH];
      default:  result_s = {DWIDTH{1'b0}};
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      MD_IDLE: begin
        if (MD_Start) state_nxt_s = MD_CALC;
        else          state_nxt_s = MD_IDLE;
      end
      MD_CALC: begin
        if (MD_Kill)                 state_nxt_s = MD_IDLE;
        else if (cnt_r == CNT_ONE)   state_nxt_s = MD_FIX;
        else                         state_nxt_s = MD_CALC;
      end
      MD_FIX:  state_nxt_s = MD_IDLE;
      default: state_nxt_s = MD_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) state_r <= MD_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Datapath and registered outputs.
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      op_r     <= MD_MUL;
      cnt_r    <= {CNT_W{1'b0}};
      opnd_r   <= {DWIDTH{1'b0}};
      a_orig_r <= {DWIDTH{1'b0}};
      acc_r    <= {(2*DWIDTH){1'b0}};
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      b_zero_r <= 1'b0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      out_r    <= {DWIDTH{1'b0}};
      zero_r   <= 1'b1;
    end else begin
      busy_r  <= (state_nxt_s != MD_IDLE);
      valid_r <= (state_r == MD_FIX) && !MD_Kill;
      case (state_r)
        MD_IDLE: begin
          if (MD_Start) begin
            op_r     <= op_in_s;
            cnt_r    <= CNT_INIT;
            sign_a_r <= sa_s;
            sign_b_r <= sb_s;
            b_zero_r <= (MD_In_B == {DWIDTH{1'b0}});
            a_orig_r <= MD_In_A;
            opnd_r   <= md_is_div(op_in_s) ? b_abs_s : a_abs_s;
            acc_r    <= {{DWIDTH{1'b0}}, (md_is_div(op_in_s) ? a_abs_s : b_abs_s)};
          end
        end
        MD_CALC: begin
          if (!MD_Kill) begin
            cnt_r <= cnt_r - CNT_ONE;
            acc_r <= md_is_div(op_r) ? div_nxt_s : mul_nxt_s;
          end
        end
        MD_FIX: begin
          if (!MD_Kill) begin
            out_r  <= result_s;
            zero_r <= (result_s == {DWIDTH{1'b0}});
          end
        end
        default: cnt_r <= {CNT_W{1'b0}};
      endcase
    end
  end

  assign MD_Busy      = busy_r;
  assign MD_Valid     = valid_r;
  assign MD_Out       = out_r;
  assign MD_Zero_Flag = zero_r;

endmodule
